// File: rtl/sram_slot_arbiter.sv
// Time-slot controller for a single external SRAM: periodic VGA read, clear-after-read,
// and round-robin program writes into the back buffer of a double-buffered frame.
module sram_slot_arbiter #(
  parameter int DATA_W    = 16,
  parameter int X_W       = 10,
  parameter int Y_W       = 9,
  parameter int ADDR_W    = 20,
  parameter int N_WR      = 2,
  parameter int ROUND_LEN = 4
) (
  input  logic                   sram_clk,
  input  logic                   reset_n,
  input  logic                   sram_b_clk,
  input  logic                   frame_clk,
  input  logic [N_WR-1:0]        wr_valid,
  output logic [N_WR-1:0]        wr_ready,
  input  logic [N_WR*X_W-1:0]    wr_x,
  input  logic [N_WR*Y_W-1:0]    wr_y,
  input  logic [N_WR*DATA_W-1:0] wr_data,
  input  logic                   bg_enable,
  input  logic [DATA_W-1:0]      bg_data,
  input  logic [X_W-1:0]         vga_x,
  input  logic [Y_W-1:0]         vga_y,
  output logic [DATA_W-1:0]      vga_data,
  output logic                   vga_data_valid,
  output logic                   display_frame,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_WE_N,
  output logic [ADDR_W-1:0]      SRAM_ADDR,
  inout  wire  [DATA_W-1:0]      SRAM_DQ
);

  localparam int CNT_W = $clog2(ROUND_LEN);
  localparam int IDX_W = (N_WR > 1) ? $clog2(N_WR) : 1;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(ROUND_LEN - 1);

  if (ADDR_W != 1 + Y_W + X_W) begin : g_addr_w_check
    $error("ADDR_W must equal 1+Y_W+X_W");
  end
  if (N_WR < 1 || N_WR > 8) begin : g_n_wr_check
    $error("N_WR must be in 1..8");
  end
  if (ROUND_LEN < 3) begin : g_round_len_check
    $error("ROUND_LEN must be >= 3");
  end

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_sync_reg;
  logic       rst_n_int;

  always_ff @(posedge sram_clk or negedge reset_n) begin
    if (!reset_n) rst_sync_reg <= 2'b00;
    else          rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign rst_n_int = rst_sync_reg[1];

  logic [X_W-1:0]    cli_x    [N_WR];
  logic [Y_W-1:0]    cli_y    [N_WR];
  logic [DATA_W-1:0] cli_data [N_WR];

  logic [CNT_W-1:0]  slot_cnt_reg, slot_cnt_next;
  logic              display_frame_reg, display_frame_next;
  logic              swap_pending_reg, swap_pending_next;
  logic              bg_pending_reg, bg_pending_next;
  logic [ADDR_W-1:0] bg_addr_reg, bg_addr_next;
  logic [IDX_W-1:0]  rr_ptr_reg, rr_ptr_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              write_en_reg, write_en_next;
  logic              read_en_reg, read_en_next;
  logic [DATA_W-1:0] vga_data_reg, vga_data_next;
  logic              vga_valid_reg, vga_valid_next;
  logic [2:0]        frame_sync_reg;

  logic              frame_rise;
  logic              win_found;
  logic [IDX_W-1:0]  win_idx;
  logic [IDX_W:0]    cand;
  logic              grant_ok;
  logic [ADDR_W-1:0] rd_addr;

  genvar gi;
  for (gi = 0; gi < N_WR; gi++) begin : g_client
    assign cli_x[gi]    = wr_x[gi*X_W +: X_W];
    assign cli_y[gi]    = wr_y[gi*Y_W +: Y_W];
    assign cli_data[gi] = wr_data[gi*DATA_W +: DATA_W];
    assign wr_ready[gi] = grant_ok && (win_idx == IDX_W'(gi));
  end

  always_ff @(posedge sram_clk or negedge rst_n_int) begin
    if (!rst_n_int) frame_sync_reg <= 3'b000;
    else            frame_sync_reg <= {frame_sync_reg[1:0], frame_clk};
  end
  assign frame_rise = frame_sync_reg[1] & ~frame_sync_reg[2];

  // Scan clients from rr_ptr upward; iterating downward lets the nearest one win.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = N_WR - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_reg} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_WR)) cand = cand - (IDX_W+1)'(N_WR);
      if (wr_valid[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign grant_ok = rst_n_int && (slot_cnt_reg != '0) && !bg_pending_reg && win_found;
  assign rd_addr  = {display_frame_reg, vga_y, vga_x};

  always_comb begin
    slot_cnt_next      = (slot_cnt_reg == LAST_SLOT) ? '0 : slot_cnt_reg + 1'b1;
    display_frame_next = display_frame_reg;
    swap_pending_next  = swap_pending_reg | frame_rise;
    bg_pending_next    = bg_pending_reg;
    bg_addr_next       = bg_addr_reg;
    rr_ptr_next        = rr_ptr_reg;
    addr_next          = addr_reg;
    wdata_next         = wdata_reg;
    write_en_next      = 1'b0;
    read_en_next       = 1'b0;
    vga_valid_next     = read_en_reg;
    vga_data_next      = read_en_reg ? SRAM_DQ : vga_data_reg;

    // Buffers only swap on the round boundary, so a round never straddles two frames.
    if (slot_cnt_reg == LAST_SLOT && swap_pending_next) begin
      display_frame_next = ~display_frame_reg;
      swap_pending_next  = 1'b0;
    end

    if (slot_cnt_reg == '0) begin
      read_en_next    = 1'b1;
      addr_next       = rd_addr;
      bg_addr_next    = rd_addr;
      bg_pending_next = bg_enable;
    end else if (bg_pending_reg) begin
      write_en_next   = 1'b1;
      addr_next       = bg_addr_reg;
      wdata_next      = bg_data;
      bg_pending_next = 1'b0;
    end else if (win_found) begin
      write_en_next = 1'b1;
      addr_next     = {~display_frame_reg, cli_y[win_idx], cli_x[win_idx]};
      wdata_next    = cli_data[win_idx];
      rr_ptr_next   = (win_idx == IDX_W'(N_WR - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge sram_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      slot_cnt_reg      <= '0;
      display_frame_reg <= 1'b0;
      swap_pending_reg  <= 1'b0;
      bg_pending_reg    <= 1'b0;
      bg_addr_reg       <= '0;
      rr_ptr_reg        <= '0;
      addr_reg          <= '0;
      wdata_reg         <= '0;
      write_en_reg      <= 1'b0;
      read_en_reg       <= 1'b0;
      vga_data_reg      <= '0;
      vga_valid_reg     <= 1'b0;
    end else begin
      slot_cnt_reg      <= slot_cnt_next;
      display_frame_reg <= display_frame_next;
      swap_pending_reg  <= swap_pending_next;
      bg_pending_reg    <= bg_pending_next;
      bg_addr_reg       <= bg_addr_next;
      rr_ptr_reg        <= rr_ptr_next;
      addr_reg          <= addr_next;
      wdata_reg         <= wdata_next;
      write_en_reg      <= write_en_next;
      read_en_reg       <= read_en_next;
      vga_data_reg      <= vga_data_next;
      vga_valid_reg     <= vga_valid_next;
    end
  end

  assign vga_data       = vga_data_reg;
  assign vga_data_valid = vga_valid_reg;
  assign display_frame  = display_frame_reg;
  assign SRAM_CE_N      = 1'b0;
  assign SRAM_UB_N      = 1'b0;
  assign SRAM_LB_N      = 1'b0;
  assign SRAM_WE_N      = write_en_reg ? sram_b_clk : 1'b1;
  assign SRAM_OE_N      = read_en_reg ? sram_b_clk : 1'b1;
  assign SRAM_ADDR      = addr_reg;
  assign SRAM_DQ        = write_en_reg ? wdata_reg : {DATA_W{1'bz}};

endmodule
